// File: rtl/down_counter_mux.sv
// Two-digit down counter: an 8-bit binary counter and a two-digit BCD counter run in
// lockstep from one enable, with a select that picks which one drives the display outputs.
module down_counter_mux #(
  parameter bit WRAP = 1'b1
) (
  input  logic       dcm_clk,
  input  logic       dcm_rst,
  input  logic       dcm_en,
  input  logic       dcm_load,
  input  logic [7:0] dcm_load_val,
  input  logic       dcm_select,
  output logic [7:0] dcm_out,
  output logic       dcm_borrow,
  output logic       dcm_zero
);

  logic [7:0] hex_q, hex_d;
  logic [7:0] bcd_q, bcd_d;
  logic       hex_borrow_q, hex_borrow_d;
  logic       bcd_borrow_q, bcd_borrow_d;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    hex_d        = hex_q;
    hex_borrow_d = 1'b0;
    if (dcm_load) begin
      hex_d = dcm_load_val;
    end else if (dcm_en) begin
      if (hex_q == 8'h00) begin
        if (WRAP) begin
          hex_d        = 8'hFF;
          hex_borrow_d = 1'b1;
        end
      end else begin
        hex_d = hex_q - 8'd1;
      end
    end
  end

  always_comb begin
    bcd_d        = bcd_q;
    bcd_borrow_d = 1'b0;
    if (dcm_load) begin
      bcd_d = {clamp_digit(dcm_load_val[7:4]), clamp_digit(dcm_load_val[3:0])};
    end else if (dcm_en) begin
      if (bcd_q == 8'h00) begin
        if (WRAP) begin
          bcd_d        = 8'h99;
          bcd_borrow_d = 1'b1;
        end
      end else if (bcd_q[3:0] != 4'd0) begin
        bcd_d = {bcd_q[7:4], bcd_q[3:0] - 4'd1};
      end else begin
        // Ones digit underflows: borrow from tens
        bcd_d = {bcd_q[7:4] - 4'd1, 4'd9};
      end
    end
  end

  always_ff @(posedge dcm_clk or posedge dcm_rst) begin
    if (dcm_rst) begin
      hex_q        <= 8'h00;
      bcd_q        <= 8'h00;
      hex_borrow_q <= 1'b0;
      bcd_borrow_q <= 1'b0;
    end else begin
      hex_q        <= hex_d;
      bcd_q        <= bcd_d;
      hex_borrow_q <= hex_borrow_d;
      bcd_borrow_q <= bcd_borrow_d;
    end
  end

  always_comb begin
    dcm_out    = dcm_select ? bcd_q : hex_q;
    dcm_borrow = dcm_select ? bcd_borrow_q : hex_borrow_q;
    dcm_zero   = (dcm_out == 8'h00);
  end

endmodule

// File: tb/tb_down_counter_mux.sv
// Randomized and directed bench for down_counter_mux; checks a wrapping and a
// saturating instance against an integer model of the counting rules.
module tb_down_counter_mux;

  logic       clk = 1'b0;
  logic       rst, en, load, sel;
  logic [7:0] load_val;
  logic [7:0] out_w, out_n;
  logic       borrow_w, borrow_n, zero_w, zero_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: counts held as plain integers (BCD as a decimal value 0..99)
  int m_hex, m_bcd, n_hex, n_bcd;
  bit m_hb, m_bb;

  always #5 clk = ~clk;

  down_counter_mux #(.WRAP(1'b1)) u_wrap (
    .dcm_clk(clk), .dcm_rst(rst), .dcm_en(en), .dcm_load(load), .dcm_load_val(load_val),
    .dcm_select(sel), .dcm_out(out_w), .dcm_borrow(borrow_w), .dcm_zero(zero_w)
  );

  down_counter_mux #(.WRAP(1'b0)) u_nowrap (
    .dcm_clk(clk), .dcm_rst(rst), .dcm_en(en), .dcm_load(load), .dcm_load_val(load_val),
    .dcm_select(sel), .dcm_out(out_n), .dcm_borrow(borrow_n), .dcm_zero(zero_n)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [7:0] exp_out(input logic s, input logic w);
    if (w) return s ? to_bcd(m_bcd) : 8'(m_hex);
    return s ? to_bcd(n_bcd) : 8'(n_hex);
  endfunction

  function automatic logic exp_borrow(input logic s, input logic w);
    if (w) return s ? m_bb : m_hb;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_hex = 0; m_bcd = 0; n_hex = 0; n_bcd = 0; m_hb = 0; m_bb = 0;
  endtask

  // One clock edge; the model advances from the inputs present at the edge
  task automatic tick();
    int hi, lo;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (load) begin
      hi = (load_val[7:4] > 4'd9) ? 9 : int'(load_val[7:4]);
      lo = (load_val[3:0] > 4'd9) ? 9 : int'(load_val[3:0]);
      m_hex = int'(load_val); n_hex = m_hex;
      m_bcd = hi * 10 + lo;   n_bcd = m_bcd;
      m_hb = 0; m_bb = 0;
    end else if (en) begin
      m_hb  = (m_hex == 0);
      m_bb  = (m_bcd == 0);
      m_hex = (m_hex == 0) ? 255 : m_hex - 1;
      m_bcd = (m_bcd == 0) ? 99 : m_bcd - 1;
      n_hex = (n_hex == 0) ? 0 : n_hex - 1;
      n_bcd = (n_bcd == 0) ? 0 : n_bcd - 1;
    end else begin
      m_hb = 0; m_bb = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; sel = 1'b0; load_val = 8'h00;
    model_reset();
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_tests++;
      if (out_w !== 8'h00 || zero_w !== 1'b1 || borrow_w !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_wrap sel=%0d: out=%h zero=%b borrow=%b, want 00 1 0",
                 s, out_w, zero_w, borrow_w);
      end
      n_tests++;
      if (out_n !== 8'h00 || zero_n !== 1'b1 || borrow_n !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_nowrap sel=%0d: out=%h zero=%b borrow=%b, want 00 1 0",
                 s, out_n, zero_n, borrow_n);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Directed wrap from 00 with either counter selected
  task automatic test_wrap(input logic s);
    logic [7:0] exp_seq [3];
    logic       exp_b [3];
    apply_reset();
    sel = s; load = 1'b0; en = 1'b1;
    if (s) exp_seq = '{8'h99, 8'h98, 8'h97};
    else   exp_seq = '{8'hFF, 8'hFE, 8'hFD};
    exp_b = '{1'b1, 1'b0, 1'b0};
    #1;
    n_tests++;
    if (out_w !== 8'h00 || zero_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_start sel=%0d: out=%h zero=%b, want 00 1", s, out_w, zero_w);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (out_w !== exp_seq[i] || borrow_w !== exp_b[i] || zero_w !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_seq sel=%0d step %0d: out=%h borrow=%b zero=%b, want %h %b 0",
                 s, i, out_w, borrow_w, zero_w, exp_seq[i], exp_b[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_digit_boundary();
    logic [7:0] exp_b [3];
    logic [7:0] exp_h [3];
    exp_b = '{8'h20, 8'h19, 8'h18};
    exp_h = '{8'h20, 8'h1F, 8'h1E};
    load = 1'b1; load_val = 8'h20; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      sel = 1'b1; #1;
      n_tests++;
      if (out_w !== exp_b[i]) begin
        n_fail++;
        $display("FAIL digit_bcd step %0d: out=%h, want %h", i, out_w, exp_b[i]);
      end
      sel = 1'b0; #1;
      n_tests++;
      if (out_w !== exp_h[i]) begin
        n_fail++;
        $display("FAIL digit_hex step %0d: out=%h, want %h", i, out_w, exp_h[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    logic [7:0] vals [3];
    logic [7:0] exp_h [3];
    logic [7:0] exp_b [3];
    vals  = '{8'hAB, 8'h3C, 8'hFA};
    exp_h = '{8'hAB, 8'h3C, 8'hFA};
    exp_b = '{8'h99, 8'h39, 8'h99};
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      // Load wins over enable even at 00, so no wrap and no borrow
      load = 1'b1; en = 1'b1; load_val = vals[i];
      tick();
      load = 1'b0; en = 1'b0;
      sel = 1'b0; #1;
      n_tests++;
      if (out_w !== exp_h[i] || borrow_w !== 1'b0) begin
        n_fail++;
        $display("FAIL load_hex %h: out=%h borrow=%b, want %h 0",
                 vals[i], out_w, borrow_w, exp_h[i]);
      end
      sel = 1'b1; #1;
      n_tests++;
      if (out_w !== exp_b[i] || borrow_w !== 1'b0) begin
        n_fail++;
        $display("FAIL load_bcd %h: out=%h borrow=%b, want %h 0",
                 vals[i], out_w, borrow_w, exp_b[i]);
      end
    end
  endtask

  task automatic test_nowrap();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h01, 8'h00, 8'h00, 8'h00};
    load = 1'b1; load_val = 8'h02; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int s = 0; s < 2; s++) begin
        sel = s[0]; #1;
        n_tests++;
        if (out_n !== exp_seq[i] || borrow_n !== 1'b0 || zero_n !== (exp_seq[i] == 8'h00)) begin
          n_fail++;
          $display("FAIL nowrap sel=%0d step %0d: out=%h borrow=%b zero=%b, want %h 0 %b",
                   s, i, out_n, borrow_n, zero_n, exp_seq[i], exp_seq[i] == 8'h00);
        end
      end
    end
    load = 1'b1; load_val = 8'h05;
    tick();
    load = 1'b0; en = 1'b0;
    n_tests++;
    if (out_n !== 8'h05) begin
      n_fail++;
      $display("FAIL nowrap_reload: out=%h, want 05", out_n);
    end
  endtask

  task automatic test_async_reset();
    sel = 1'b0; load = 1'b1; load_val = 8'h7D; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    n_tests++;
    if (out_w !== 8'h7C) begin
      n_fail++;
      $display("FAIL async_pre: out=%h, want 7C", out_w);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_w !== 8'h00 || zero_w !== 1'b1 || borrow_w !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: out=%h zero=%b borrow=%b, want 00 1 0",
               out_w, zero_w, borrow_w);
    end
    rst = 1'b0;
    model_reset();
    tick();
    n_tests++;
    if (out_w !== exp_out(1'b0, 1'b1) || borrow_w !== exp_borrow(1'b0, 1'b1)) begin
      n_fail++;
      $display("FAIL async_after: out=%h borrow=%b, want %h %b",
               out_w, borrow_w, exp_out(1'b0, 1'b1), exp_borrow(1'b0, 1'b1));
    end
    en = 1'b0;
  endtask

  task automatic test_select_toggle();
    load = 1'b1; load_val = 8'h57; en = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = ~sel; #1;
      n_tests++;
      if (out_w !== 8'h57 || out_n !== 8'h57) begin
        n_fail++;
        $display("FAIL select_toggle %0d: out_w=%h out_n=%h, want 57", i, out_w, out_n);
      end
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    sel = 1'b1; #1;
    n_tests++;
    if (out_w !== 8'h56) begin
      n_fail++;
      $display("FAIL select_bcd_dec: out=%h, want 56", out_w);
    end
    sel = 1'b0; #1;
    n_tests++;
    if (out_w !== 8'h56) begin
      n_fail++;
      $display("FAIL select_hex_dec: out=%h, want 56", out_w);
    end
  endtask

  task automatic test_random();
    logic [7:0] eo;
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      sel      = 1'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        eo = exp_out(sel, 1'b1);
        n_tests++;
        if (out_w !== eo || borrow_w !== exp_borrow(sel, 1'b1) || zero_w !== (eo == 8'h00)) begin
          n_fail++;
          $display("FAIL random_wrap cyc %0d sel=%b: out=%h borrow=%b zero=%b, want %h %b %b",
                   i, sel, out_w, borrow_w, zero_w, eo, exp_borrow(sel, 1'b1), eo == 8'h00);
        end
        eo = exp_out(sel, 1'b0);
        n_tests++;
        if (out_n !== eo || borrow_n !== 1'b0 || zero_n !== (eo == 8'h00)) begin
          n_fail++;
          $display("FAIL random_nowrap cyc %0d sel=%b: out=%h borrow=%b zero=%b, want %h 0 %b",
                   i, sel, out_n, borrow_n, zero_n, eo, eo == 8'h00);
        end
        sel = ~sel; #1;
      end
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap(1'b0);
    test_wrap(1'b1);
    test_digit_boundary();
    test_load_clamp();
    test_nowrap();
    test_async_reset();
    test_select_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
